// File: rtl/lp_tree_deser_pkg.sv
// Shared constants and FSM state type for the lp_tree deserializer.
// Optional parity support is selected with the LP_TREE_DESER_PARITY_EN macro.
package lp_tree_deser_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int FRAME_BITS        = DEFAULT_DATA_W + 2;
    localparam int FRAME_BITS_PARITY = DEFAULT_DATA_W + 3;

`ifdef LP_TREE_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} deser_state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, STOP} deser_state_t;
`endif

endpackage

// File: rtl/lp_tree_deser_shift.sv
// Data shift register and bit counter; the first received bit ends up in bit 0.
module lp_tree_deser_shift
    import lp_tree_deser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] shift_data,
    output logic              last_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [CNT_W-1:0] bit_cnt;

    // Right shift: after DATA_W shifts the first (LSB) bit sits at position 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bit_cnt    <= '0;
            shift_data <= '0;
        end else if (shift_en) begin
            shift_data <= {bit_in, shift_data[DATA_W-1:1]};
            bit_cnt    <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/lp_tree_deserializer.sv
// Serial-to-parallel frame receiver with valid/ready output and overrun/frame-error pulses.
// Define LP_TREE_DESER_PARITY_EN to expect an odd-parity bit between data and stop bit.
module lp_tree_deserializer
    import lp_tree_deser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SERIAL_IN,
    output logic [DATA_W-1:0] PAR_OUT,
    output logic              PAR_VALID,
    input  logic              PAR_READY,
    output logic              OVERRUN,
    output logic              FRAME_ERR
);

    deser_state_t      state, state_next;
    logic              shift_en;
    logic              commit;
    logic              reject;
    logic              frame_bad;
    logic [DATA_W-1:0] shift_data;
    logic              last_bit;

    lp_tree_deser_shift #(.DATA_W(DATA_W)) u_shift (
        .CLK        (CLK),
        .RESET      (RESET),
        .shift_en   (shift_en),
        .bit_in     (SERIAL_IN),
        .shift_data (shift_data),
        .last_bit   (last_bit)
    );

`ifdef LP_TREE_DESER_PARITY_EN
    logic parity_err;

    // Odd parity: data plus parity bit must XOR to 1; verdict is held until the stop bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            parity_err <= 1'b0;
        end else if (state == PARITY) begin
            parity_err <= ~(^{shift_data, SERIAL_IN});
        end
    end

    assign frame_bad = SERIAL_IN | parity_err;
`else
    assign frame_bad = SERIAL_IN;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (SERIAL_IN) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
`ifdef LP_TREE_DESER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef LP_TREE_DESER_PARITY_EN
            PARITY: begin
                state_next = STOP;
            end
`endif
            STOP: begin
                state_next = IDLE;
                if (frame_bad) begin
                    reject = 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new word may replace the held one only if the held one is leaving on this edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PAR_OUT   <= '0;
            PAR_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            OVERRUN   <= 1'b0;
            FRAME_ERR <= reject;
            if (PAR_VALID && PAR_READY) begin
                PAR_VALID <= 1'b0;
            end
            if (commit) begin
                if (!PAR_VALID || PAR_READY) begin
                    PAR_OUT   <= shift_data;
                    PAR_VALID <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Self-checking bench for lp_tree_deserializer: frame-level reference model plus directed scenarios.
// Parity scenarios are compiled in when LP_TREE_DESER_PARITY_EN is defined.
module tb_lp_tree_deserializer;

    localparam int W = 16;
`ifdef LP_TREE_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int STOP_POS = W + (PAR_EN ? 1 : 0);

    logic         CLK;
    logic         RESET;
    logic         SERIAL_IN;
    logic [W-1:0] PAR_OUT;
    logic         PAR_VALID;
    logic         PAR_READY;
    logic         OVERRUN;
    logic         FRAME_ERR;

    int tests_run = 0;
    int tests_failed = 0;
    int ovr_pulses = 0;
    int ferr_pulses = 0;

    lp_tree_deserializer #(.DATA_W(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SERIAL_IN (SERIAL_IN),
        .PAR_OUT   (PAR_OUT),
        .PAR_VALID (PAR_VALID),
        .PAR_READY (PAR_READY),
        .OVERRUN   (OVERRUN),
        .FRAME_ERR (FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks the position inside the frame and the output buffer.
    int           m_pos = -1;
    logic [W-1:0] m_word = '0;
    logic         m_pbit = 1'b0;
    logic [W-1:0] m_out = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;
    logic         m_ferr = 1'b0;

    always @(posedge CLK) begin
        logic good;
        logic commit;
        logic old_valid;
        if (!RESET) begin
            m_pos   = -1;
            m_out   = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            commit    = 1'b0;
            m_ovr     = 1'b0;
            m_ferr    = 1'b0;
            old_valid = m_valid;
            if (m_pos < 0) begin
                if (SERIAL_IN) begin
                    m_pos  = 0;
                    m_word = '0;
                end
            end else if (m_pos < W) begin
                m_word[m_pos] = SERIAL_IN;
                m_pos++;
            end else if (m_pos < STOP_POS) begin
                m_pbit = SERIAL_IN;
                m_pos++;
            end else begin
                good = (SERIAL_IN == 1'b0) && (!PAR_EN || (((^m_word) ^ m_pbit) == 1'b1));
                if (good) commit = 1'b1;
                else m_ferr = 1'b1;
                m_pos = -1;
            end
            if (old_valid && PAR_READY) m_valid = 1'b0;
            if (commit) begin
                if (!old_valid || PAR_READY) begin
                    m_out   = m_word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        #1;
        if (OVERRUN === 1'b1) ovr_pulses++;
        if (FRAME_ERR === 1'b1) ferr_pulses++;
        checkOutput("model PAR_VALID", {31'd0, PAR_VALID}, {31'd0, m_valid});
        checkOutput("model PAR_OUT", {16'd0, PAR_OUT}, {16'd0, m_out});
        checkOutput("model OVERRUN", {31'd0, OVERRUN}, {31'd0, m_ovr});
        checkOutput("model FRAME_ERR", {31'd0, FRAME_ERR}, {31'd0, m_ferr});
    end

    task automatic applyStimulus(input logic bit_v, input logic ready_v);
        @(negedge CLK);
        SERIAL_IN = bit_v;
        PAR_READY = ready_v;
    endtask

    task automatic sendFrame(input logic [W-1:0] word, input logic stop_bit, input logic par_bit, input logic ready_v);
        applyStimulus(1'b1, ready_v);
        for (int i = 0; i < W; i++) applyStimulus(word[i], ready_v);
        if (PAR_EN) applyStimulus(par_bit, ready_v);
        applyStimulus(stop_bit, ready_v);
    endtask

    function automatic logic oddPar(input logic [W-1:0] word);
        return ~(^word);
    endfunction

    initial begin
        int base;
        RESET     = 1'b0;
        SERIAL_IN = 1'b0;
        PAR_READY = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset PAR_VALID", {31'd0, PAR_VALID}, 32'd0);
        checkOutput("reset PAR_OUT", {16'd0, PAR_OUT}, 32'd0);
        checkOutput("reset OVERRUN", {31'd0, OVERRUN}, 32'd0);
        checkOutput("reset FRAME_ERR", {31'd0, FRAME_ERR}, 32'd0);
        RESET = 1'b1;

        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("idle PAR_VALID", {31'd0, PAR_VALID}, 32'd0);
        checkOutput("idle overrun count", ovr_pulses, 32'd0);
        checkOutput("idle frame_err count", ferr_pulses, 32'd0);

        // Single frame, consumer ready: valid for exactly one cycle.
        sendFrame(16'hC5AF, 1'b0, oddPar(16'hC5AF), 1'b1);
        checkOutput("C5AF early valid", {31'd0, PAR_VALID}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("C5AF valid", {31'd0, PAR_VALID}, 32'd1);
        checkOutput("C5AF data", {16'd0, PAR_OUT}, 32'h0000C5AF);
        applyStimulus(1'b0, 1'b1);
        checkOutput("C5AF one cycle", {31'd0, PAR_VALID}, 32'd0);

        // Back-to-back frames with stalled consumer: second word overruns.
        base = ovr_pulses;
        sendFrame(16'h1234, 1'b0, oddPar(16'h1234), 1'b0);
        sendFrame(16'hABCD, 1'b0, oddPar(16'hABCD), 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("overrun pulse", {31'd0, OVERRUN}, 32'd1);
        checkOutput("overrun keeps old", {16'd0, PAR_OUT}, 32'h00001234);
        checkOutput("overrun valid", {31'd0, PAR_VALID}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("overrun count", ovr_pulses - base, 32'd1);
        checkOutput("stall stable", {16'd0, PAR_OUT}, 32'h00001234);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("drain valid", {31'd0, PAR_VALID}, 32'd0);

        // Bad stop bit, then a good frame.
        base = ferr_pulses;
        sendFrame(16'h00FF, 1'b1, oddPar(16'h00FF), 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop err pulse", {31'd0, FRAME_ERR}, 32'd1);
        checkOutput("stop err valid", {31'd0, PAR_VALID}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop err count", ferr_pulses - base, 32'd1);
        sendFrame(16'h3C3C, 1'b0, oddPar(16'h3C3C), 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("recover valid", {31'd0, PAR_VALID}, 32'd1);
        checkOutput("recover data", {16'd0, PAR_OUT}, 32'h00003C3C);
        applyStimulus(1'b0, 1'b1);

        // Reset in the middle of a frame discards it silently.
        base = ferr_pulses;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        @(negedge CLK);
        RESET     = 1'b0;
        SERIAL_IN = 1'b0;
        #1;
        checkOutput("midreset valid", {31'd0, PAR_VALID}, 32'd0);
        checkOutput("midreset data", {16'd0, PAR_OUT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        sendFrame(16'h5A5A, 1'b0, oddPar(16'h5A5A), 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("post reset valid", {31'd0, PAR_VALID}, 32'd1);
        checkOutput("post reset data", {16'd0, PAR_OUT}, 32'h00005A5A);
        applyStimulus(1'b0, 1'b1);
        checkOutput("post reset no ferr", ferr_pulses - base, 32'd0);

`ifdef LP_TREE_DESER_PARITY_EN
        sendFrame(16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("parity ok valid", {31'd0, PAR_VALID}, 32'd1);
        checkOutput("parity ok data", {16'd0, PAR_OUT}, 32'h00000001);
        applyStimulus(1'b0, 1'b1);
        base = ferr_pulses;
        sendFrame(16'h0001, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("parity bad pulse", {31'd0, FRAME_ERR}, 32'd1);
        checkOutput("parity bad valid", {31'd0, PAR_VALID}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("parity bad count", ferr_pulses - base, 32'd1);
`endif

        repeat (4) applyStimulus(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lp_tree_deserializer.md
LP_TREE_DESERIALIZER -- requirements
Module: lp_tree_deserializer

Interface
REQ-001 Parameter: DATA_W, default 16, payload bits per frame.
REQ-002 Port: CLK  input  1  sole clock; all sampling and state changes on rising edge.
REQ-003 Port: RESET  input  1  asynchronous, active-low reset.
REQ-004 Port: SERIAL_IN  input  1  serial line from the upstream lp_tree_serializer stage; idle level 0.
REQ-005 Port: PAR_OUT  output  DATA_W  reassembled word.
REQ-006 Port: PAR_VALID  output  1  PAR_OUT holds an untransferred word.
REQ-007 Port: PAR_READY  input  1  consumer accepts the word at this edge.
REQ-008 Port: OVERRUN  output  1  one-cycle pulse: a completed word was dropped.
REQ-009 Port: FRAME_ERR  output  1  one-cycle pulse: a frame was rejected.

Function
REQ-010 Frame, without the Configuration macro, SHALL be: start bit 1, DATA_W data bits LSB first, stop bit 0, one bit per rising edge.
REQ-011 FSM SHALL have states IDLE, SHIFT and STOP; only IDLE→SHIFT (SERIAL_IN=1 sampled), SHIFT→STOP (after DATA_W data bits), STOP→IDLE.
REQ-012 In IDLE, a sampled 0 SHALL leave the FSM in IDLE with no other effect.
REQ-013 In SHIFT, a bit counter SHALL count 0..DATA_W-1 and the shift register SHALL take one bit per edge, so bit k lands in position k.
REQ-014 In STOP, a sampled 0 SHALL commit the word; a sampled 1 SHALL discard it and pulse FRAME_ERR.
REQ-015 A committed word SHALL appear on PAR_OUT with PAR_VALID=1 in the cycle after the stop-bit edge, i.e. DATA_W+2 edges after the start-bit edge.
REQ-016 Back-to-back frames SHALL be accepted: a start bit on the edge right after the stop bit is honoured.
REQ-017 Transfer SHALL occur on an edge where PAR_VALID=1 and PAR_READY=1; PAR_VALID then clears unless a new commit occurs on the same edge.
REQ-018 Commit with transfer on the same edge SHALL load the new word and keep PAR_VALID=1.
REQ-019 Commit while PAR_VALID=1 and PAR_READY=0 SHALL keep the old word, drop the new one and pulse OVERRUN.
REQ-020 PAR_OUT and PAR_VALID SHALL be stable while PAR_VALID=1 and PAR_READY=0.
REQ-021 Shifting SHALL continue independently of the output handshake, giving a two-stage buffer: shift register plus output register.

Reset
REQ-022 RESET=0 SHALL immediately force: state IDLE, counter 0, shift register 0, PAR_OUT 0, PAR_VALID 0, OVERRUN 0, FRAME_ERR 0.
REQ-023 Reset mid-frame SHALL discard the partial word with no FRAME_ERR; after release, the first sampled 1 is a start bit.

Configuration
REQ-024 Macro LP_TREE_DESER_PARITY_EN defined: a parity bit follows the data bits; the FSM adds a PARITY state between SHIFT and STOP; latency is DATA_W+3 edges.
REQ-025 With the macro, the frame SHALL have odd parity over data plus parity bit; a mismatch SHALL discard the word and pulse FRAME_ERR at the stop-bit edge, even if the stop bit is valid.
REQ-026 Without the macro, there SHALL be no PARITY state and no parity logic.

Structure
REQ-027 Package lp_tree_deser_pkg SHALL hold the default DATA_W, the FSM state enum and the frame-length constants, both with and without parity.
REQ-028 Sub-module lp_tree_deser_shift SHALL contain the shift register and bit counter; the top level holds the FSM, output register and handshake.

Verification
REQ-029 Reset, idle line of 0 for 20 cycles → PAR_VALID, OVERRUN and FRAME_ERR all 0.
REQ-030 Frame carrying 16'hC5AF, PAR_READY=1 → PAR_OUT=16'hC5AF with PAR_VALID high exactly 18 edges after the start edge, for 1 cycle.
REQ-031 Two back-to-back frames, 16'h1234 then 16'hABCD, PAR_READY=0 → PAR_OUT stays 16'h1234, OVERRUN pulses once; then PAR_READY=1 → transfer and PAR_VALID drops.
REQ-032 Frame 16'h00FF with stop bit 1 → FRAME_ERR pulses once, PAR_VALID stays 0, and the next valid frame is received correctly.
REQ-033 RESET pulsed low after 8 data bits, then a full frame of 16'h5A5A → only 16'h5A5A is delivered, with no FRAME_ERR.
REQ-034 With LP_TREE_DESER_PARITY_EN: frame 16'h0001 with parity 0 is accepted; the same frame with parity 1 → FRAME_ERR pulses and no word is delivered.
